instr_fetch_queue: RTL and testbench

//  Instruction buffer between the instruction re-aligner and the decode stage.

---
 rtl/instr_fetch_queue_if.sv | 70 +++++++
 rtl/instr_fetch_queue.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
//   Bundles the handshake and data signals that pass between the
//   instruction re-aligner, the instruction fetch queue and the decode stage.
//   Signal names are written from the queue's point of view: *_i is driven
//   into the queue and *_o is driven by it.
//
//   Re-aligner side : valid_i, instr_i, pc_i, compressed_i -> ready_o
//   Decode side     : valid_o, instr_o, pc_o, compressed_o <- ready_i
//   Controller      : flush_i
//   Status          : count_o (occupancy), pc_stall_o (almost full)
//
//   modport slave  : the queue itself
//   modport master : whatever drives the queue (re-aligner/decode/controller
//                    collectively, or a testbench)
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_WIDTH = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                flush_i;
  logic                valid_i;
  logic [31:0]         instr_i;
  logic [PC_WIDTH-1:0] pc_i;
  logic                compressed_i;
  logic                ready_o;

  logic                valid_o;
  logic [31:0]         instr_o;
  logic [PC_WIDTH-1:0] pc_o;
  logic                compressed_o;
  logic                ready_i;

  logic [CW-1:0]       count_o;
  logic                pc_stall_o;

  modport slave (
    input  flush_i,
    input  valid_i,
    input  instr_i,
    input  pc_i,
    input  compressed_i,
    output ready_o,
    output valid_o,
    output instr_o,
    output pc_o,
    output compressed_o,
    input  ready_i,
    output count_o,
    output pc_stall_o
  );

  modport master (
    output flush_i,
    output valid_i,
    output instr_i,
    output pc_i,
    output compressed_i,
    input  ready_o,
    input  valid_o,
    input  instr_o,
    input  pc_o,
    input  compressed_o,
    output ready_i,
    input  count_o,
    input  pc_stall_o
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   In-order instruction buffer between the re-aligner and decode. Each entry
//   holds an instruction word, its PC and its compressed flag. Entries are
//   accepted with valid_i/ready_o and released with valid_o/ready_i.
//   A flush from the controller discards every buffered entry.
//
//   Ports
//     clk_i   : clock
//     rst_ni  : asynchronous reset, active low
//     fq      : instr_fetch_queue_if.slave
//               flush_i                              controller flush
//               valid_i/instr_i/pc_i/compressed_i    write side
//               ready_o                              not full (or flushing)
//               valid_o/instr_o/pc_o/compressed_o    head entry (0 when empty)
//               ready_i                              decode takes the head
//               count_o                              occupied entries
//               pc_stall_o                           count_o >= DEPTH-1
//
//   Storage is a circular buffer indexed by $clog2(DEPTH)-bit read/write
//   pointers plus an explicit occupancy count, so full and empty are told
//   apart without a spare pointer bit. The head is a combinational read of
//   the entry at the read pointer; a pushed entry first appears one cycle
//   after it is written, so there is never a same-cycle fall-through path.
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  instr_fetch_queue_if.slave  fq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_STALL = CW'(DEPTH - 1);

  // Pointer advance. DEPTH is a power of two, so the natural overflow of the
  // AW-bit add is exactly the modulo-DEPTH wrap.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return ptr + AW'(1);
  endfunction

  // Control state
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Entry storage (data only, never reset)
  logic [31:0]         instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic                comp_mem  [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A flush cycle swallows both sides: nothing is written and the head is not
  // consumed. Pushes are gated on the registered full flag only, so a pop in
  // the same cycle never frees space for a push (no bypass).
  assign push = fq.valid_i & ~full  & ~fq.flush_i;
  assign pop  = fq.ready_i & ~empty & ~fq.flush_i;

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (fq.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry write; the compressed flag is kept exactly as presented
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= fq.instr_i;
      pc_mem[wr_ptr_q]    <= fq.pc_i;
      comp_mem[wr_ptr_q]  <= fq.compressed_i;
    end
  end

  // Head read and status. Gating the head with empty makes the data outputs
  // read 0 both when the queue drains and immediately on reset, because the
  // asynchronous reset clears count_q.
  always_comb begin
    fq.valid_o      = ~empty;
    fq.instr_o      = '0;
    fq.pc_o         = '0;
    fq.compressed_o = 1'b0;
    if (!empty) begin
      fq.instr_o      = instr_mem[rd_ptr_q];
      fq.pc_o         = pc_mem[rd_ptr_q];
      fq.compressed_o = comp_mem[rd_ptr_q];
    end
  end

  // ready_o is held high through a flush so the re-aligner never waits on a
  // queue that is about to be emptied anyway.
  assign fq.ready_o    = ~full | fq.flush_i;
  assign fq.count_o    = count_q;
  // One entry early, so the fetch already in flight still has a slot.
  assign fq.pc_stall_o = (count_q >= CNT_STALL);

  // Structural invariants
  a_count_bound : assert property (
    @(posedge clk_i) disable iff (!rst_ni) count_q <= CNT_FULL);

  a_no_overflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(push && full));

  a_no_underflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(pop && empty));

  a_stable_head : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      (fq.valid_o && !fq.ready_i && !fq.flush_i)
      |=> (fq.valid_o && $stable(fq.instr_o) && $stable(fq.pc_o)
           && $stable(fq.compressed_o)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Directed scenarios followed by randomized traffic, all compared against a
//   queue-based reference model of the buffer.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PCW   = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_fetch_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .fq     (bus.slave)
  );

  typedef struct packed {
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
    logic           comp;
  } ent_t;

  ent_t model[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model for the current state and inputs
  task automatic cmp_outputs(input logic fl);
    int n;
    n = model.size();
    check("count", 64'(bus.count_o), 64'(n));
    check("valid", 64'(bus.valid_o), 64'(n != 0));
    check("ready", 64'(bus.ready_o), 64'((n < int'(DEPTH)) || fl));
    check("stall", 64'(bus.pc_stall_o), 64'(n >= int'(DEPTH) - 1));
    if (n != 0) begin
      check("instr", 64'(bus.instr_o), 64'(model[0].instr));
      check("pc", 64'(bus.pc_o), 64'(model[0].pc));
      check("comp", 64'(bus.compressed_o), 64'(model[0].comp));
    end else begin
      check("instr0", 64'(bus.instr_o), 64'(0));
      check("pc0", 64'(bus.pc_o), 64'(0));
      check("comp0", 64'(bus.compressed_o), 64'(0));
    end
  endtask

  // One clock cycle: apply inputs, check, advance the model at the edge
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [PCW-1:0] pc,
                     input logic c, input logic rdy, input logic fl);
    logic do_push;
    logic do_pop;
    ent_t e;
    bus.valid_i      = v;
    bus.instr_i      = ins;
    bus.pc_i         = pc;
    bus.compressed_i = c;
    bus.ready_i      = rdy;
    bus.flush_i      = fl;
    #1;
    cmp_outputs(fl);
    do_push = v && (model.size() < int'(DEPTH)) && !fl;
    do_pop  = rdy && (model.size() > 0) && !fl;
    e.instr = ins;
    e.pc    = pc;
    e.comp  = c;
    @(posedge clk);
    if (fl) begin
      model.delete();
    end else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back(e);
    end
    @(negedge clk);
  endtask

  function automatic logic is_comp(input logic [31:0] ins);
    return ins[1:0] != 2'b11;
  endfunction

  initial begin
    logic [31:0] rins;
    rst_n            = 1'b0;
    bus.valid_i      = 1'b0;
    bus.instr_i      = '0;
    bus.pc_i         = '0;
    bus.compressed_i = 1'b0;
    bus.ready_i      = 1'b0;
    bus.flush_i      = 1'b0;
    repeat (2) @(negedge clk);
    cmp_outputs(1'b0);
    rst_n = 1'b1;

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'h0000_0013 + 32'(i << 8), PCW'(4 * i), 1'b0, 1'b0, 1'b0);
      if (i == 2) check("stall_at3", 64'(bus.pc_stall_o), 64'(1));
    end
    check("full_ready", 64'(bus.ready_o), 64'(0));
    check("full_count", 64'(bus.count_o), 64'(4));

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(bus.pc_o), 64'(4 * i));
      cyc(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);
    end
    check("drain_empty", 64'(bus.valid_o), 64'(0));

    // Simultaneous push/pop at count 2 across pointer wrap
    cyc(1'b1, 32'h0010_0093, PCW'(32'h100), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_0093, PCW'(32'h104), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check("pp_count", 64'(bus.count_o), 64'(2));
      check("pp_pc", 64'(bus.pc_o), 64'(32'h100 + 4 * k));
      cyc(1'b1, 32'h0030_0093 + 32'(k << 12), PCW'(32'h108 + 4 * k), 1'b0, 1'b1, 1'b0);
    end
    check("pp_count_end", 64'(bus.count_o), 64'(2));

    // Back to full, then push while popping at full
    cyc(1'b1, 32'h0040_0093, PCW'(32'h180), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0050_0093, PCW'(32'h184), 1'b0, 1'b0, 1'b0);
    check("full2_count", 64'(bus.count_o), 64'(4));
    cyc(1'b1, 32'hDEAD_BEEF, PCW'(32'h200), 1'b0, 1'b1, 1'b0);
    check("full_pop_cnt", 64'(bus.count_o), 64'(3));

    // Flush at count 3 while a push is offered
    cyc(1'b1, 32'h00A0_0093, PCW'(32'h300), 1'b0, 1'b0, 1'b1);
    check("flush_count", 64'(bus.count_o), 64'(0));
    check("flush_valid", 64'(bus.valid_o), 64'(0));
    cyc(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);

    // Mixed compressed / 32-bit entries
    cyc(1'b1, 32'h0000_4501, PCW'(32'h10), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h0050_0113, PCW'(32'h12), 1'b0, 1'b0, 1'b0);
    check("mix_c1", 64'(bus.compressed_o), 64'(1));
    check("mix_pc1", 64'(bus.pc_o), 64'(32'h10));
    cyc(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);
    check("mix_c0", 64'(bus.compressed_o), 64'(0));
    check("mix_pc2", 64'(bus.pc_o), 64'(32'h12));
    check("mix_instr2", 64'(bus.instr_o), 64'(32'h0050_0113));
    cyc(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h0060_0093 + 32'(i), PCW'(32'h400 + 4 * i), 1'b0, 1'b0, 1'b0);
    end
    check("pre_rst_count", 64'(bus.count_o), 64'(3));
    bus.valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.valid_o), 64'(0));
    check("rst_count", 64'(bus.count_o), 64'(0));
    check("rst_ready", 64'(bus.ready_o), 64'(1));
    check("rst_pc", 64'(bus.pc_o), 64'(0));
    check("rst_stall", 64'(bus.pc_stall_o), 64'(0));
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      rins = $urandom;
      cyc($urandom_range(0, 3) != 0, rins, PCW'($urandom), is_comp(rins),
          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
